// File: rtl/control_memoria_datos_pkg.sv
// Shared definitions for the data-memory controller: FSM encodings and address-width helper.
package control_memoria_datos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DUMP_RD = 2'd1,
    ST_DUMP_TX = 2'd2,
    ST_CLEAR   = 2'd3
  } state_t;

  // Number of bits needed to represent 'value' (1024 -> 11).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/control_memoria_datos.sv
// Arbitrates the memoria_datos port between the MEM stage and the debug unit, and
// sequences a dirty-range dump or a full clear while the processor is halted.
module control_memoria_datos
  import control_memoria_datos_pkg::*;
#(
  parameter int RAM_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_soft_reset,
  input  logic                  i_halt,
  input  logic [ADDR_WIDTH-1:0] i_pipe_addr,
  input  logic [RAM_WIDTH-1:0]  i_pipe_data,
  input  logic                  i_pipe_wea,
  input  logic                  i_pipe_ena,
  input  logic                  i_cmd_dump,
  input  logic                  i_cmd_clear,
  input  logic                  i_dump_ready,
  input  logic [RAM_WIDTH-1:0]  i_mem_data,
  input  logic                  i_mem_reset_ack,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr_bit_sucio,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [RAM_WIDTH-1:0]  o_mem_data,
  output logic                  o_mem_wea,
  output logic                  o_mem_ena,
  output logic                  o_mem_soft_reset,
  output logic [RAM_WIDTH-1:0]  o_dump_data,
  output logic [ADDR_WIDTH-1:0] o_dump_addr,
  output logic                  o_dump_valid,
  output logic                  o_dump_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_abort,
  output logic [1:0]            o_state
);

  localparam int LAT_W = clogb2(READ_LATENCY);

  // Dump handshake: a word transfers on a rising edge where o_dump_valid and
  // i_dump_ready are both high; while valid is high and ready is low, data,
  // address and last are held unchanged.

  state_t                state;
  logic [ADDR_WIDTH-1:0] dump_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [LAT_W-1:0]      lat_cnt;

  assign o_state = state;

  always_comb begin
    o_mem_addr = i_pipe_addr;
    o_mem_data = i_pipe_data;
    o_mem_wea  = i_pipe_wea;
    o_mem_ena  = i_pipe_ena;
    case (state)
      ST_IDLE: begin
        if (i_halt) begin
          o_mem_ena = 1'b0;
          o_mem_wea = 1'b0;
        end
      end
      ST_DUMP_RD, ST_DUMP_TX: begin
        o_mem_addr = dump_cnt;
        o_mem_ena  = 1'b1;
        o_mem_wea  = 1'b0;
      end
      ST_CLEAR: begin
        o_mem_ena = 1'b0;
        o_mem_wea = 1'b0;
      end
      default: begin
        o_mem_ena = 1'b0;
        o_mem_wea = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state            <= ST_IDLE;
      dump_cnt         <= '0;
      last_addr        <= '0;
      lat_cnt          <= '0;
      o_dump_data      <= '0;
      o_dump_addr      <= '0;
      o_dump_valid     <= 1'b0;
      o_dump_last      <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_abort          <= 1'b0;
      o_mem_soft_reset <= 1'b1;
    end else begin
      o_done  <= 1'b0;
      o_abort <= 1'b0;
      if (state != ST_IDLE && !i_halt) begin
        // Processor resumed: hand the port back immediately, whatever was in flight.
        state            <= ST_IDLE;
        o_busy           <= 1'b0;
        o_abort          <= 1'b1;
        o_dump_valid     <= 1'b0;
        o_dump_last      <= 1'b0;
        o_mem_soft_reset <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_halt && i_cmd_dump) begin
              state     <= ST_DUMP_RD;
              o_busy    <= 1'b1;
              last_addr <= i_mem_addr_bit_sucio;
              dump_cnt  <= '0;
              lat_cnt   <= '0;
            end else if (i_halt && i_cmd_clear) begin
              state            <= ST_CLEAR;
              o_busy           <= 1'b1;
              o_mem_soft_reset <= 1'b0;
            end
          end
          ST_DUMP_RD: begin
            // The memory samples the address one edge after it is driven, so the
            // word is captured READ_LATENCY edges after that.
            if (lat_cnt == LAT_W'(READ_LATENCY)) begin
              state        <= ST_DUMP_TX;
              o_dump_data  <= i_mem_data;
              o_dump_addr  <= dump_cnt;
              o_dump_valid <= 1'b1;
              o_dump_last  <= (dump_cnt == last_addr);
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          ST_DUMP_TX: begin
            if (i_dump_ready) begin
              o_dump_valid <= 1'b0;
              o_dump_last  <= 1'b0;
              if (o_dump_last) begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end else begin
                state    <= ST_DUMP_RD;
                dump_cnt <= dump_cnt + 1'b1;
                lat_cnt  <= '0;
              end
            end
          end
          ST_CLEAR: begin
            if (i_mem_reset_ack) begin
              state            <= ST_IDLE;
              o_busy           <= 1'b0;
              o_done           <= 1'b1;
              o_mem_soft_reset <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_memoria_datos.sv
// Directed bench for control_memoria_datos with a registered memory model and a dump scoreboard.
module tb_control_memoria_datos;

  localparam int DW        = 32;
  localparam int AW        = 11;
  localparam int EW        = 1 + AW + DW;
  localparam int ACK_DELAY = 6000;

  logic          clk;
  logic          rst_n;
  logic          i_halt;
  logic [AW-1:0] i_pipe_addr;
  logic [DW-1:0] i_pipe_data;
  logic          i_pipe_wea;
  logic          i_pipe_ena;
  logic          i_cmd_dump;
  logic          i_cmd_clear;
  logic          i_dump_ready;
  logic [DW-1:0] i_mem_data;
  logic          i_mem_reset_ack;
  logic [AW-1:0] i_mem_addr_bit_sucio;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_mem_wea;
  logic          o_mem_ena;
  logic          o_mem_soft_reset;
  logic [DW-1:0] o_dump_data;
  logic [AW-1:0] o_dump_addr;
  logic          o_dump_valid;
  logic          o_dump_last;
  logic          o_busy;
  logic          o_done;
  logic          o_abort;
  logic [1:0]    o_state;

  control_memoria_datos #(.RAM_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .i_clk(clk), .i_soft_reset(rst_n), .i_halt(i_halt),
    .i_pipe_addr(i_pipe_addr), .i_pipe_data(i_pipe_data),
    .i_pipe_wea(i_pipe_wea), .i_pipe_ena(i_pipe_ena),
    .i_cmd_dump(i_cmd_dump), .i_cmd_clear(i_cmd_clear), .i_dump_ready(i_dump_ready),
    .i_mem_data(i_mem_data), .i_mem_reset_ack(i_mem_reset_ack),
    .i_mem_addr_bit_sucio(i_mem_addr_bit_sucio),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_wea(o_mem_wea),
    .o_mem_ena(o_mem_ena), .o_mem_soft_reset(o_mem_soft_reset),
    .o_dump_data(o_dump_data), .o_dump_addr(o_dump_addr), .o_dump_valid(o_dump_valid),
    .o_dump_last(o_dump_last), .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort),
    .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return 32'h1234_0000 + ({21'd0, a} * 32'h0001_0003);
  endfunction

  int low_cnt;
  always @(posedge clk) begin
    i_mem_data <= word_of(o_mem_addr);
    if (o_mem_soft_reset) begin
      low_cnt         <= 0;
      i_mem_reset_ack <= 1'b0;
    end else begin
      low_cnt         <= low_cnt + 1;
      i_mem_reset_ack <= (low_cnt + 1 >= ACK_DELAY);
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec;
  int n_fail;
  int done_cnt;
  int abort_cnt;
  int wea_busy_cnt;
  int sr_low_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input int a, input int last_a);
    logic [AW-1:0] aa;
    aa = AW'(a);
    exp_q.push_back({(a == last_a), aa, word_of(aa)});
  endtask

  logic          prev_hold;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_done) done_cnt++;
      if (o_abort) abort_cnt++;
      if (o_busy && o_mem_wea) wea_busy_cnt++;
      if (!o_mem_soft_reset) sr_low_cnt++;
      if (prev_hold && o_dump_valid) begin
        check("hold_data", {32'd0, o_dump_data}, {32'd0, prev_data});
        check("hold_addr", {53'd0, o_dump_addr}, {53'd0, prev_addr});
      end
      if (o_dump_valid && i_dump_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_word: got addr %0h data %0h expected none", o_dump_addr, o_dump_data);
        end else begin
          e = exp_q.pop_front();
          check("dump_addr", {53'd0, o_dump_addr}, {53'd0, e[DW +: AW]});
          check("dump_data", {32'd0, o_dump_data}, {32'd0, e[DW-1:0]});
          check("dump_last", {63'd0, o_dump_last}, {63'd0, e[EW-1]});
        end
      end
      prev_hold = o_dump_valid && !i_dump_ready;
      prev_data = o_dump_data;
      prev_addr = o_dump_addr;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input int last_a, input int stall_addr, input int stall_len);
    int guard;
    int stalls;
    bit fin;
    int d0;
    d0 = done_cnt;
    for (int a = 0; a <= last_a; a++) push_word(a, last_a);
    i_dump_ready         = 1'b1;
    i_mem_addr_bit_sucio = AW'(last_a);
    i_cmd_dump           = 1'b1;
    tick();
    i_cmd_dump           = 1'b0;
    // Later changes of the dirty pointer must not affect the running dump.
    i_mem_addr_bit_sucio = AW'(last_a + 5);
    guard  = 0;
    stalls = 0;
    fin    = 1'b0;
    while (!fin && guard < 5000) begin
      tick();
      guard++;
      if (o_done) fin = 1'b1;
      if (o_dump_valid && o_dump_addr == AW'(stall_addr) && stalls < stall_len) begin
        i_dump_ready = 1'b0;
        stalls++;
      end else begin
        i_dump_ready = 1'b1;
      end
    end
    check("dump_finished", {63'd0, fin}, 64'd1);
    tick();
    check("dump_queue_empty", 64'(exp_q.size()), 64'd0);
    check("dump_done_once", 64'(done_cnt - d0), 64'd1);
    check("dump_idle_after", {63'd0, o_busy}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int d0;
  int a0;
  int s0;
  int guard;
  bit fin;

  initial begin
    n_vec = 0; n_fail = 0; done_cnt = 0; abort_cnt = 0; wea_busy_cnt = 0; sr_low_cnt = 0;
    rst_n = 1'b0; i_halt = 1'b0;
    i_pipe_addr = '0; i_pipe_data = '0; i_pipe_wea = 1'b0; i_pipe_ena = 1'b0;
    i_cmd_dump = 1'b0; i_cmd_clear = 1'b0; i_dump_ready = 1'b0;
    i_mem_addr_bit_sucio = '0;
    tick(); tick();
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_valid", {63'd0, o_dump_valid}, 64'd0);
    check("rst_soft_reset", {63'd0, o_mem_soft_reset}, 64'd1);
    check("rst_dump_data", {32'd0, o_dump_data}, 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // 1: passthrough while running; commands ignored.
    i_pipe_wea = 1'b1; i_pipe_ena = 1'b1; i_pipe_addr = 11'd5; i_pipe_data = 32'hDB;
    #1;
    check("pass_addr", {53'd0, o_mem_addr}, 64'd5);
    check("pass_data", {32'd0, o_mem_data}, 64'hDB);
    check("pass_wea", {63'd0, o_mem_wea}, 64'd1);
    check("pass_ena", {63'd0, o_mem_ena}, 64'd1);
    i_cmd_dump = 1'b1;
    tick();
    i_cmd_dump = 1'b0;
    tick();
    check("ignored_cmd_busy", {63'd0, o_busy}, 64'd0);
    i_halt = 1'b1;
    #1;
    check("halt_idle_ena", {63'd0, o_mem_ena}, 64'd0);
    check("halt_idle_wea", {63'd0, o_mem_wea}, 64'd0);

    // 2: three-word dump, pipe keeps requesting writes.
    wea_busy_cnt = 0;
    run_dump(2, 0, 0);
    check("dump_wea_low", 64'(wea_busy_cnt), 64'd0);

    // 3: back-pressure on word 1.
    run_dump(2, 1, 5);

    // Single-word and full-depth dumps.
    run_dump(0, 0, 0);
    run_dump(1023, 0, 0);

    // 4: clear with a slow acknowledge; a dump request mid-clear is ignored.
    d0 = done_cnt;
    s0 = sr_low_cnt;
    i_dump_ready = 1'b1;
    i_cmd_clear = 1'b1;
    tick();
    i_cmd_clear = 1'b0;
    repeat (100) tick();
    i_cmd_dump = 1'b1;
    tick();
    i_cmd_dump = 1'b0;
    tick();
    check("clear_busy", {63'd0, o_busy}, 64'd1);
    check("clear_soft_low", {63'd0, o_mem_soft_reset}, 64'd0);
    check("clear_ena_low", {63'd0, o_mem_ena}, 64'd0);
    guard = 0; fin = 1'b0;
    while (!fin && guard < ACK_DELAY + 500) begin
      tick();
      guard++;
      if (o_done) fin = 1'b1;
    end
    check("clear_finished", {63'd0, fin}, 64'd1);
    check("clear_soft_released", {63'd0, o_mem_soft_reset}, 64'd1);
    tick(); tick();
    check("clear_low_cycles", 64'(sr_low_cnt - s0), 64'(ACK_DELAY + 1));
    check("clear_done_once", 64'(done_cnt - d0), 64'd1);
    check("clear_no_dump", {63'd0, o_busy}, 64'd0);

    // 5: abort a long dump at word 10.
    d0 = done_cnt;
    a0 = abort_cnt;
    for (int a = 0; a < 10; a++) push_word(a, 1023);
    i_dump_ready = 1'b1;
    i_mem_addr_bit_sucio = 11'd1023;
    i_cmd_dump = 1'b1;
    tick();
    i_cmd_dump = 1'b0;
    guard = 0; fin = 1'b0;
    while (!fin && guard < 500) begin
      tick();
      guard++;
      if (o_dump_valid && o_dump_addr == 11'd10) begin
        i_dump_ready = 1'b0;
        fin = 1'b1;
      end
    end
    check("abort_reached_word10", {63'd0, fin}, 64'd1);
    i_halt = 1'b0;
    i_pipe_addr = 11'd77; i_pipe_data = 32'hCAFE_0077; i_pipe_wea = 1'b1; i_pipe_ena = 1'b1;
    tick();
    check("abort_pulse", {63'd0, o_abort}, 64'd1);
    check("abort_valid_low", {63'd0, o_dump_valid}, 64'd0);
    check("abort_busy_low", {63'd0, o_busy}, 64'd0);
    check("abort_pass_addr", {53'd0, o_mem_addr}, 64'd77);
    check("abort_pass_wea", {63'd0, o_mem_wea}, 64'd1);
    tick();
    check("abort_pulse_end", {63'd0, o_abort}, 64'd0);
    check("abort_count", 64'(abort_cnt - a0), 64'd1);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6: simultaneous commands -> dump; then async reset mid-dump.
    i_halt = 1'b1;
    i_dump_ready = 1'b0;
    i_mem_addr_bit_sucio = 11'd3;
    i_cmd_dump = 1'b1; i_cmd_clear = 1'b1;
    tick();
    i_cmd_dump = 1'b0; i_cmd_clear = 1'b0;
    guard = 0; fin = 1'b0;
    while (!fin && guard < 50) begin
      tick();
      guard++;
      if (o_dump_valid) fin = 1'b1;
    end
    check("both_cmd_dump_runs", {63'd0, fin}, 64'd1);
    check("both_cmd_first_addr", {53'd0, o_dump_addr}, 64'd0);
    check("both_cmd_no_clear", {63'd0, o_mem_soft_reset}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {63'd0, o_dump_valid}, 64'd0);
    check("rst_mid_last", {63'd0, o_dump_last}, 64'd0);
    check("rst_mid_busy", {63'd0, o_busy}, 64'd0);
    check("rst_mid_done_abort", {62'd0, o_done, o_abort}, 64'd0);
    check("rst_mid_soft", {63'd0, o_mem_soft_reset}, 64'd1);
    check("rst_mid_data", {32'd0, o_dump_data}, 64'd0);
    check("rst_mid_addr", {53'd0, o_dump_addr}, 64'd0);
    check("rst_mid_mem_ena", {63'd0, o_mem_ena}, 64'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
